sw_mailbox: RTL

Hardware-side endpoint of the software register interface. It buffers 32-bit descriptor words that software writes (`interface_out_en`/`interface_out`) into a TX FIFO and drains them to the ingress/packet-validation path with valid/ready. It collects egress metadata words into an RX FIFO, presents the head word to software on `interface_in`, and pops one entry per `interface_out_ack` cycle.

---
 rtl/sw_mailbox_pkg.sv | 19 +
 rtl/sw_mailbox_sync_fifo.sv | 66 ++++++
 rtl/sw_mailbox.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sw_mailbox_pkg.sv
// ---------------------------------------------------------------------------
// mailbox_pkg
// Shared widths, bit positions and defaults for the software mailbox.
//   MBOX_DATA_W        : software bus / descriptor word width
//   RD_VALID_BIT       : bit of sw_rd_data that flags a valid RX head
//   egr_meta_t         : egress metadata word type
//   MBOX_DEFAULT_DEPTH : default entries per FIFO
//   MBOX_DEFAULT_CNT_W : default statistics counter width
// ---------------------------------------------------------------------------
package mailbox_pkg;

    localparam int unsigned MBOX_DATA_W        = 32;
    localparam int unsigned RD_VALID_BIT       = 31;
    localparam int unsigned MBOX_DEFAULT_DEPTH = 8;
    localparam int unsigned MBOX_DEFAULT_CNT_W = 16;

    typedef logic [RD_VALID_BIT-1:0] egr_meta_t;

endpackage : mailbox_pkg

// File: rtl/sw_mailbox_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered pointers one bit wider than the address
// so full and empty are distinguishable (wrap modulo 2*DEPTH).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_flush      : synchronous clear of pointers, wins over push/pop
//   i_push/i_din : write request and data
//   i_pop        : read request (ignored while empty)
//   o_dout       : head word (valid while !o_empty)
//   o_full/o_empty/o_level : status derived from registered pointers
// A push while full is accepted only when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_do_pop  = i_pop && !o_empty;
    // Full-but-popping frees the head slot this edge, so the write fits.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only observed through the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule : sync_fifo

// File: rtl/sw_mailbox.sv
// ---------------------------------------------------------------------------
// sw_mailbox
// Hardware endpoint of the software register interface.
//   TX: software descriptor writes (sw_wr_en/sw_wr_data) -> FIFO -> ingress
//       valid/ready (ing_valid/ing_data/ing_ready). Writes on a full FIFO
//       with no simultaneous pop are dropped and counted.
//   RX: egress metadata (egr_valid/egr_data/egr_ready) -> FIFO -> software
//       read word sw_rd_data = {valid, head}; sw_rd_ack pops one entry.
//   clk, reset  : clock, asynchronous active-high reset
//   flush       : synchronous clear of both FIFOs (drop counter kept)
//   tx_drop_cnt : saturating TX drop counter
//   rx_level    : RX occupancy
// Build option: define MAILBOX_STATS_EN to make tx_drop_cnt and rx_level
// live; otherwise both read 0 and the counter logic is absent.
// ---------------------------------------------------------------------------
module sw_mailbox
    import mailbox_pkg::*;
#(
    parameter int unsigned DEPTH = MBOX_DEFAULT_DEPTH,
    parameter int unsigned CNT_W = MBOX_DEFAULT_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     sw_wr_en,
    input  logic [MBOX_DATA_W-1:0]   sw_wr_data,
    input  logic                     sw_rd_ack,
    output logic [MBOX_DATA_W-1:0]   sw_rd_data,
    output logic                     ing_valid,
    output logic [MBOX_DATA_W-1:0]   ing_data,
    input  logic                     ing_ready,
    input  logic                     egr_valid,
    input  egr_meta_t                egr_data,
    output logic                     egr_ready,
    output logic [CNT_W-1:0]         tx_drop_cnt,
    output logic [$clog2(DEPTH):0]   rx_level
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic            w_tx_full;
    logic            w_tx_empty;
    logic            w_tx_pop;
    logic [LW-1:0]   w_tx_level;
    logic            w_rx_full;
    logic            w_rx_empty;
    logic            w_rx_push;
    logic            w_rx_pop;
    logic [LW-1:0]   w_rx_level;
    egr_meta_t       w_rx_head;

    assign ing_valid = !w_tx_empty;
    assign w_tx_pop  = ing_valid && ing_ready;

    assign egr_ready = !w_rx_full;
    assign w_rx_push = egr_valid && egr_ready;
    assign w_rx_pop  = sw_rd_ack && !w_rx_empty;

    assign sw_rd_data = w_rx_empty ? '0 : {1'b1, w_rx_head};

    sync_fifo #(
        .W     (MBOX_DATA_W),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_flush (flush),
        .i_push  (sw_wr_en),
        .i_din   (sw_wr_data),
        .i_pop   (w_tx_pop),
        .o_dout  (ing_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_level (w_tx_level)
    );

    sync_fifo #(
        .W     (RD_VALID_BIT),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_flush (flush),
        .i_push  (w_rx_push),
        .i_din   (egr_data),
        .i_pop   (w_rx_pop),
        .o_dout  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_level (w_rx_level)
    );

`ifdef MAILBOX_STATS_EN
    logic [CNT_W-1:0] r_tx_drop_cnt;
    logic             w_tx_drop;
    logic             w_unused;

    // A write during flush is discarded by the flush, not counted as a drop.
    assign w_tx_drop = sw_wr_en && w_tx_full && !w_tx_pop && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_drop_cnt <= '0;
        end else if (w_tx_drop && (r_tx_drop_cnt != '1)) begin
            r_tx_drop_cnt <= r_tx_drop_cnt + 1'b1;
        end
    end

    assign tx_drop_cnt = r_tx_drop_cnt;
    assign rx_level    = w_rx_level;
    assign w_unused    = &{1'b0, w_tx_level};
`else
    logic w_unused;

    assign tx_drop_cnt = '0;
    assign rx_level    = '0;
    assign w_unused    = &{1'b0, w_tx_level, w_rx_level, w_tx_full};
`endif

endmodule : sw_mailbox
